// File: rtl/wdt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_pkg
//  Description : Shared types and constants for the multi-channel watchdog:
//                channel state encoding, register map and a width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package wdt_pkg;

  // Channel state encoding; the spare code 2'd3 falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } wdt_state_e;

  // Register map seen through wr_addr.
  localparam logic [1:0] CTRL   = 2'd0;
  localparam logic [1:0] TOCNT  = 2'd1;
  localparam logic [1:0] WINCNT = 2'd2;
  localparam logic [1:0] KICK   = 2'd3;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wdt_channel.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_channel
//  Description : One watchdog channel: timeout/window registers, up-counter
//                and IDLE/RUN/EXPIRED state machine with registered irq/cause.
//  Revision    : 1.0 - initial release
// ============================================================================
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_addr_i,
  input  logic [CNT_W-1:0] wr_data_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             irq_o,
  output logic             cause_o
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tocnt_q, tocnt_d;
  logic [CNT_W-1:0] wincnt_q, wincnt_d;
  logic             winmode_q, winmode_d;
  logic             irq_q, irq_d;
  logic             cause_q, cause_d;

  logic ctrl_wr, tocnt_wr, wincnt_wr, kick_wr;

  assign ctrl_wr   = wr_en_i && (wr_addr_i == CTRL);
  assign tocnt_wr  = wr_en_i && (wr_addr_i == TOCNT);
  assign wincnt_wr = wr_en_i && (wr_addr_i == WINCNT);
  assign kick_wr   = wr_en_i && (wr_addr_i == KICK);

  // Next-state logic: kick beats tick, disable beats everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tocnt_d   = tocnt_q;
    wincnt_d  = wincnt_q;
    winmode_d = winmode_q;
    irq_d     = irq_q;
    cause_d   = cause_q;

    if (ctrl_wr) winmode_d = wr_data_i[1];

    // Limits are frozen once the channel has expired.
    if (state_q != EXPIRED) begin
      if (tocnt_wr)  tocnt_d  = wr_data_i;
      if (wincnt_wr) wincnt_d = wr_data_i;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ctrl_wr && wr_data_i[0]) state_d = RUN;
      end
      RUN: begin
        if (kick_wr) begin
          if (!winmode_q || (cnt_q >= wincnt_q)) begin
            cnt_d = '0;
          end else begin
            state_d = EXPIRED;
            irq_d   = 1'b1;
            cause_d = 1'b1;
          end
        end else if (tick_i) begin
          // >= rather than == so a limit lowered below the running count
          // expires on the next tick instead of letting the counter wrap.
          if (cnt_q >= tocnt_q) begin
            state_d = EXPIRED;
            irq_d   = 1'b1;
            cause_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EXPIRED: begin
        irq_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (ctrl_wr && !wr_data_i[0]) begin
      state_d = IDLE;
      cnt_d   = '0;
      irq_d   = 1'b0;
      cause_d = 1'b0;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tocnt_q   <= '1;
      wincnt_q  <= '0;
      winmode_q <= 1'b0;
      irq_q     <= 1'b0;
      cause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tocnt_q   <= tocnt_d;
      wincnt_q  <= wincnt_d;
      winmode_q <= winmode_d;
      irq_q     <= irq_d;
      cause_q   <= cause_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign irq_o   = irq_q;
  assign cause_o = cause_q;

endmodule
`default_nettype wire

// File: rtl/wdt_multi.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_multi
//  Description : Multi-channel watchdog: shared prescaler, per-channel write
//                decode and counter readback mux around NUM_CH channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [1:0]         wr_addr,
  input  logic [CNT_W-1:0]   wr_data,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [NUM_CH-1:0]  irq,
  output logic [NUM_CH-1:0]  cause
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;
  logic [CNT_W-1:0]   cnt_all [NUM_CH];

  // Prescaler: >= keeps a divisor shrunk mid-count from stalling a full wrap.
  always_comb begin
    tick    = (presc_q >= presc_div);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  // Free-running prescaler count.
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // Out-of-range wr_ch matches no channel, so such writes are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && (32'(wr_ch) == 32'(g));

    wdt_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .wr_en_i   (ch_wr),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .cnt_o     (cnt_all[g]),
      .irq_o     (irq[g]),
      .cause_o   (cause[g])
    );
  end

  // Combinational counter readback; unused selects read as zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(rd_ch) == 32'(i)) rd_cnt = cnt_all[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wdt_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wdt_multi
//  Description : Directed scoreboard bench for wdt_multi (3 channels, 8-bit
//                counters). Stimulus queues expected outputs tagged with the
//                clock edge they apply to; a monitor checks them after that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wdt_multi;
  import wdt_pkg::*;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int CH_W    = 2;

  localparam int K_IRQ   = 0;
  localparam int K_CAUSE = 1;
  localparam int K_CNT   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PRESC_W-1:0] presc_div = '0;
  logic               wr_en = 1'b0;
  logic [CH_W-1:0]    wr_ch = '0;
  logic [1:0]         wr_addr = '0;
  logic [CNT_W-1:0]   wr_data = '0;
  logic [CH_W-1:0]    rd_ch = '0;
  logic [CNT_W-1:0]   rd_cnt;
  logic [NUM_CH-1:0]  irq;
  logic [NUM_CH-1:0]  cause;

  wdt_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .presc_div(presc_div), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_ch(rd_ch), .rd_cnt(rd_cnt),
    .irq(irq), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Expectation for the outputs after the k-th upcoming clock edge.
  task automatic push(input int k, input int kind, input logic [31:0] exp, input string name);
    sb.push_back('{due: cyc + k, kind: kind, exp: exp, name: name});
  endtask

  // Monitor: count edges, then compare every entry due at this edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          logic [31:0] act;
          case (sb[i].kind)
            K_IRQ:   act = 32'(irq);
            K_CAUSE: act = 32'(cause);
            default: act = 32'(rd_cnt);
          endcase
          checks++;
          if (sb[i].due < cyc) begin
            errors++;
            $display("FAIL %s: stale entry due %0d seen at %0d", sb[i].name, sb[i].due, cyc);
          end else if (act !== sb[i].exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", sb[i].name, act, sb[i].exp, cyc);
          end
          sb.delete(i);
        end
      end
    end
  end

  // One-cycle register write; call at a falling edge.
  task automatic wr(input int ch, input logic [1:0] addr, input logic [CNT_W-1:0] data);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [PRESC_W-1:0] div);
    presc_div = div;
    rst       = 1'b1;
    wr_en     = 1'b0;
    push(1, K_IRQ,   0, "rst_irq");
    push(1, K_CAUSE, 0, "rst_cause");
    push(1, K_CNT,   0, "rst_cnt");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);

    // Reset state, tick every cycle.
    do_reset(8'd0);

    // Plain timeout: TOCNT=5, expiry after the tick that sees 5.
    rd_ch = 0;
    wr(0, TOCNT, 8'd5);
    push(6, K_CNT,   5, "to_cnt_at_limit");
    push(6, K_IRQ,   0, "to_no_irq_yet");
    push(7, K_IRQ,   3'b001, "to_irq");
    push(7, K_CAUSE, 0, "to_cause");
    push(9, K_CNT,   5, "to_cnt_frozen");
    wr(0, CTRL, 8'd1);
    idle(9);
    push(1, K_IRQ, 3'b001, "expired_kick_ignored");
    push(1, K_CNT, 5, "expired_cnt_kept");
    wr(0, KICK, 8'd0);
    push(1, K_IRQ, 0, "disable_clears_irq");
    push(1, K_CNT, 0, "disable_clears_cnt");
    wr(0, CTRL, 8'd0);

    // Window mode: WINCNT=4, TOCNT=10.
    wr(0, TOCNT, 8'd10);
    wr(0, WINCNT, 8'd4);
    wr(0, CTRL, 8'd3);
    idle(6);
    push(1, K_CNT, 0, "win_kick_at6");
    push(1, K_IRQ, 0, "win_kick_at6_irq");
    wr(0, KICK, 8'd0);
    idle(4);
    push(1, K_CNT, 0, "win_kick_at_wincnt");
    push(1, K_IRQ, 0, "win_kick_at_wincnt_irq");
    wr(0, KICK, 8'd0);
    idle(2);
    push(1, K_IRQ,   3'b001, "win_violation_irq");
    push(1, K_CAUSE, 3'b001, "win_violation_cause");
    push(3, K_CNT,   2, "win_violation_cnt");
    wr(0, KICK, 8'd0);
    idle(2);
    push(1, K_IRQ,   0, "win_disable_irq");
    push(1, K_CAUSE, 0, "win_disable_cause");
    wr(0, CTRL, 8'd0);

    // Kick coincident with the deciding tick at counter==TOCNT.
    wr(0, TOCNT, 8'd3);
    wr(0, CTRL, 8'd1);
    idle(3);
    push(1, K_CNT, 0, "kick_at_tocnt_cnt");
    push(1, K_IRQ, 0, "kick_at_tocnt_irq");
    push(2, K_CNT, 1, "kick_at_tocnt_resume");
    wr(0, KICK, 8'd0);
    idle(1);
    wr(0, CTRL, 8'd0);

    // TOCNT=0 expires on the first tick.
    wr(0, TOCNT, 8'd0);
    push(1, K_IRQ, 0, "tocnt0_run");
    push(2, K_IRQ, 3'b001, "tocnt0_expire");
    push(2, K_CNT, 0, "tocnt0_cnt");
    wr(0, CTRL, 8'd1);
    idle(2);
    wr(0, CTRL, 8'd0);

    // TOCNT lowered while running takes effect on the next compare.
    wr(0, TOCNT, 8'd50);
    wr(0, CTRL, 8'd1);
    idle(2);
    push(1, K_IRQ, 0, "tocnt_update_pre");
    push(2, K_IRQ, 3'b001, "tocnt_live_update");
    wr(0, TOCNT, 8'd3);
    idle(1);
    wr(0, CTRL, 8'd0);

    // Two channels: ch1 left to expire, ch0 kicked regularly.
    rd_ch = 1;
    wr(1, TOCNT, 8'd4);
    wr(0, TOCNT, 8'd100);
    wr(1, CTRL, 8'd1);
    wr(0, CTRL, 8'd1);
    push(3, K_IRQ,   0, "mc_before");
    push(4, K_IRQ,   3'b010, "mc_ch1_expire");
    push(4, K_CAUSE, 0, "mc_ch1_cause");
    push(8, K_IRQ,   3'b010, "mc_ch0_kicked");
    push(8, K_CNT,   4, "mc_ch1_frozen");
    for (int i = 0; i < 4; i++) begin
      idle(1);
      wr(0, KICK, 8'd0);
    end
    push(1, K_IRQ, 0, "mc_ch1_disable");
    wr(1, CTRL, 8'd0);
    rd_ch = 0;
    push(1, K_CNT, 2, "mc_ch0_unaffected");
    idle(1);

    // Out-of-range channel select is ignored.
    rd_ch = 2;
    push(3, K_CNT, 0, "bad_ch_ignored");
    wr(3, CTRL, 8'd1);
    idle(3);

    // Reset with ch0 running and ch1 expired.
    rd_ch = 0;
    wr(1, TOCNT, 8'd0);
    wr(1, CTRL, 8'd1);
    idle(2);
    push(1, K_IRQ, 3'b010, "pre_rst_irq");
    idle(1);
    do_reset(8'd0);
    idle(2);
    push(1, K_CNT, 0, "post_rst_idle");
    idle(1);

    // Reset TOCNT is all-ones: count reaches 255 and expires without wrap.
    rd_ch = 2;
    push(256, K_CNT, 255, "allones_cnt");
    push(256, K_IRQ, 0, "allones_pre");
    push(257, K_IRQ, 3'b100, "allones_expire");
    wr(2, CTRL, 8'd1);
    idle(258);

    // Prescaler divide-by-4: ticks at edges 4, 8, 12 after reset.
    rd_ch = 0;
    do_reset(8'd3);
    wr(0, TOCNT, 8'd2);
    wr(0, CTRL, 8'd1);
    push(1,  K_CNT, 0, "presc_cnt0");
    push(2,  K_CNT, 1, "presc_tick1");
    push(5,  K_CNT, 1, "presc_hold");
    push(6,  K_CNT, 2, "presc_tick2");
    push(9,  K_IRQ, 0, "presc_pre");
    push(10, K_IRQ, 3'b001, "presc_expire");
    idle(11);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
